clock_step_controller: RTL and testbench

//   Sequences the SAP-1 CPU clock from the debounced front-panel buttons.

---
 rtl/clock_step_controller.sv | 99 +++++++++
 tb/tb_clock_step_controller.sv | 234 +++++++++++++++++++++++
 2 files changed

// File: rtl/clock_step_controller.sv
// Front-panel clock sequencer for the SAP-1 CPU.
// It has three modes: manual single-step, free-run from a prescaler, and halted.
// It emits a one-cycle clock-enable pulse per CPU cycle and counts the pulses issued.
module clock_step_controller #(
   parameter logic [15:0] RUN_DIV = 16'd50000
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       step_n,
   input  logic       mode_n,
   input  logic       halt_i,
   output logic       clk_en,
   output logic       run_led,
   output logic       halted_led,
   output logic [7:0] cycle_count
);

   typedef enum logic [1:0] {
      StManual = 2'd0,
      StRun    = 2'd1,
      StHalted = 2'd2
   } state_e;

   state_e      state_q, state_d;
   logic [15:0] prescale_q, prescale_d;
   logic        clk_en_q, clk_en_d;
   logic [7:0]  cycle_count_q, cycle_count_d;
   logic        step_prev_q, mode_prev_q;
   logic        step_press, mode_press;

   // Falling edge of the active-low buttons; holding a button yields one press only.
   assign step_press = step_prev_q & ~step_n;
   assign mode_press = mode_prev_q & ~mode_n;

   // Next-state: halt dominates every state; presses are only honoured in MANUAL/RUN.
   always_comb begin
      state_d    = state_q;
      prescale_d = prescale_q;
      clk_en_d   = 1'b0;
      if (halt_i) begin
         state_d = StHalted;
      end else begin
         unique case (state_q)
            StHalted: begin
               state_d = StHalted;
            end
            StManual: begin
               if (mode_press) begin
                  // Mode wins over a simultaneous step press.
                  state_d    = StRun;
                  prescale_d = 16'd0;
               end else if (step_press) begin
                  clk_en_d = 1'b1;
               end
            end
            StRun: begin
               if (mode_press) begin
                  state_d    = StManual;
                  prescale_d = 16'd0;
               end else if (prescale_q == RUN_DIV - 16'd1) begin
                  clk_en_d   = 1'b1;
                  prescale_d = 16'd0;
               end else begin
                  prescale_d = prescale_q + 16'd1;
               end
            end
            default: begin
               state_d = StManual;
            end
         endcase
      end
      cycle_count_d = cycle_count_q + {7'd0, clk_en_d};
   end

   // State, prescaler, pulse and counter registers with synchronous reset.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q       <= StManual;
         prescale_q    <= 16'd0;
         clk_en_q      <= 1'b0;
         cycle_count_q <= 8'd0;
         step_prev_q   <= 1'b1;
         mode_prev_q   <= 1'b1;
      end else begin
         state_q       <= state_d;
         prescale_q    <= prescale_d;
         clk_en_q      <= clk_en_d;
         cycle_count_q <= cycle_count_d;
         step_prev_q   <= step_n;
         mode_prev_q   <= mode_n;
      end
   end

   assign clk_en      = clk_en_q;
   assign cycle_count = cycle_count_q;
   assign run_led     = (state_q == StRun);
   assign halted_led  = (state_q == StHalted);

endmodule

// File: tb/tb_clock_step_controller.sv
// Directed self-checking bench for clock_step_controller with RUN_DIV=4.
module tb_clock_step_controller;

   logic       clk = 1'b0;
   logic       rst;
   logic       step_n;
   logic       mode_n;
   logic       halt_i;
   logic       clk_en;
   logic       run_led;
   logic       halted_led;
   logic [7:0] cycle_count;

   int n_cmp  = 0;
   int n_fail = 0;

   clock_step_controller #(
      .RUN_DIV(16'd4)
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .step_n     (step_n),
      .mode_n     (mode_n),
      .halt_i     (halt_i),
      .clk_en     (clk_en),
      .run_led    (run_led),
      .halted_led (halted_led),
      .cycle_count(cycle_count)
   );

   always #5 clk = ~clk;

   // Advance one edge; outputs are then stable for sampling and inputs may change.
   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset;
      rst = 1'b1;
      for (int i = 0; i < 3; i++) begin
         step_n = 1'($urandom_range(0, 1));
         mode_n = 1'($urandom_range(0, 1));
         halt_i = 1'($urandom_range(0, 1));
         tick();
      end
      n_cmp++; if (clk_en !== 1'b0) begin n_fail++;
         $display("FAIL reset_clk_en: got %b want 0", clk_en); end
      n_cmp++; if (run_led !== 1'b0) begin n_fail++;
         $display("FAIL reset_run_led: got %b want 0", run_led); end
      n_cmp++; if (halted_led !== 1'b0) begin n_fail++;
         $display("FAIL reset_halted_led: got %b want 0", halted_led); end
      n_cmp++; if (cycle_count !== 8'd0) begin n_fail++;
         $display("FAIL reset_count: got %0d want 0", cycle_count); end
      rst    = 1'b0;
      step_n = 1'b1;
      mode_n = 1'b1;
      halt_i = 1'b0;
      tick();
   endtask

   task automatic test_manual_step;
      int pulses;
      pulses = 0;
      for (int r = 0; r < 3; r++) begin
         step_n = 1'b0;
         tick();
         n_cmp++; if (clk_en !== 1'b1) begin n_fail++;
            $display("FAIL step_pulse%0d: got %b want 1", r, clk_en); end
         if (clk_en === 1'b1) pulses++;
         for (int i = 1; i < 20; i++) begin
            tick();
            if (clk_en === 1'b1) pulses++;
         end
         step_n = 1'b1;
         tick();
         if (clk_en === 1'b1) pulses++;
      end
      n_cmp++; if (pulses != 3) begin n_fail++;
         $display("FAIL step_pulse_total: got %0d want 3", pulses); end
      n_cmp++; if (cycle_count !== 8'd3) begin n_fail++;
         $display("FAIL step_count: got %0d want 3", cycle_count); end
   endtask

   task automatic test_run;
      logic exp;
      mode_n = 1'b0;
      tick();
      mode_n = 1'b1;
      n_cmp++; if (run_led !== 1'b1) begin n_fail++;
         $display("FAIL run_enter_led: got %b want 1", run_led); end
      n_cmp++; if (clk_en !== 1'b0) begin n_fail++;
         $display("FAIL run_enter_clk_en: got %b want 0", clk_en); end
      for (int k = 1; k <= 12; k++) begin
         step_n = (k == 6) ? 1'b0 : 1'b1;
         tick();
         exp = ((k % 4) == 0);
         n_cmp++; if (clk_en !== exp) begin n_fail++;
            $display("FAIL run_pulse_k%0d: got %b want %b", k, clk_en, exp); end
      end
      step_n = 1'b1;
      n_cmp++; if (cycle_count !== 8'd6) begin n_fail++;
         $display("FAIL run_count: got %0d want 6", cycle_count); end
      mode_n = 1'b0;
      tick();
      mode_n = 1'b1;
      n_cmp++; if (run_led !== 1'b0) begin n_fail++;
         $display("FAIL run_exit_led: got %b want 0", run_led); end
      for (int k = 0; k < 8; k++) begin
         tick();
         n_cmp++; if (clk_en !== 1'b0) begin n_fail++;
            $display("FAIL run_stopped_k%0d: got %b want 0", k, clk_en); end
      end
      n_cmp++; if (cycle_count !== 8'd6) begin n_fail++;
         $display("FAIL run_exit_count: got %0d want 6", cycle_count); end
   endtask

   task automatic test_halt;
      mode_n = 1'b0;
      tick();
      mode_n = 1'b1;
      tick();
      tick();
      tick();
      // The fourth edge after entering RUN would pulse; halt takes it instead.
      halt_i = 1'b1;
      tick();
      n_cmp++; if (clk_en !== 1'b0) begin n_fail++;
         $display("FAIL halt_no_pulse: got %b want 0", clk_en); end
      n_cmp++; if (halted_led !== 1'b1) begin n_fail++;
         $display("FAIL halt_led: got %b want 1", halted_led); end
      n_cmp++; if (run_led !== 1'b0) begin n_fail++;
         $display("FAIL halt_run_led: got %b want 0", run_led); end
      halt_i = 1'b0;
      step_n = 1'b0;
      tick();
      n_cmp++; if (clk_en !== 1'b0) begin n_fail++;
         $display("FAIL halt_step_ignored: got %b want 0", clk_en); end
      step_n = 1'b1;
      tick();
      mode_n = 1'b0;
      tick();
      mode_n = 1'b1;
      for (int k = 0; k < 6; k++) tick();
      n_cmp++; if (halted_led !== 1'b1) begin n_fail++;
         $display("FAIL halt_sticky: got %b want 1", halted_led); end
      n_cmp++; if (run_led !== 1'b0) begin n_fail++;
         $display("FAIL halt_mode_ignored: got %b want 0", run_led); end
      n_cmp++; if (cycle_count !== 8'd6) begin n_fail++;
         $display("FAIL halt_count_frozen: got %0d want 6", cycle_count); end
      rst = 1'b1;
      tick();
      rst = 1'b0;
      n_cmp++; if (halted_led !== 1'b0) begin n_fail++;
         $display("FAIL halt_rst_led: got %b want 0", halted_led); end
      n_cmp++; if (cycle_count !== 8'd0) begin n_fail++;
         $display("FAIL halt_rst_count: got %0d want 0", cycle_count); end
      tick();
   endtask

   task automatic test_simultaneous;
      step_n = 1'b0;
      mode_n = 1'b0;
      tick();
      step_n = 1'b1;
      mode_n = 1'b1;
      n_cmp++; if (run_led !== 1'b1) begin n_fail++;
         $display("FAIL simul_run_led: got %b want 1", run_led); end
      n_cmp++; if (clk_en !== 1'b0) begin n_fail++;
         $display("FAIL simul_clk_en: got %b want 0", clk_en); end
      tick();
      mode_n = 1'b0;
      tick();
      mode_n = 1'b1;
      tick();
      n_cmp++; if (run_led !== 1'b0) begin n_fail++;
         $display("FAIL simul_back_manual: got %b want 0", run_led); end
      n_cmp++; if (cycle_count !== 8'd0) begin n_fail++;
         $display("FAIL simul_count: got %0d want 0", cycle_count); end
   endtask

   task automatic test_wrap;
      for (int s = 1; s <= 257; s++) begin
         step_n = 1'b0;
         tick();
         step_n = 1'b1;
         tick();
         if (s == 256) begin
            n_cmp++; if (cycle_count !== 8'd0) begin n_fail++;
               $display("FAIL wrap_256: got %0d want 0", cycle_count); end
         end
      end
      n_cmp++; if (cycle_count !== 8'd1) begin n_fail++;
         $display("FAIL wrap_257: got %0d want 1", cycle_count); end
      mode_n = 1'b0;
      tick();
      mode_n = 1'b1;
      tick();
      tick();
      rst = 1'b1;
      tick();
      rst = 1'b0;
      n_cmp++; if (run_led !== 1'b0) begin n_fail++;
         $display("FAIL wrap_rst_mid_run: got %b want 0", run_led); end
      n_cmp++; if (cycle_count !== 8'd0) begin n_fail++;
         $display("FAIL wrap_rst_count: got %0d want 0", cycle_count); end
      mode_n = 1'b0;
      tick();
      mode_n = 1'b1;
      for (int k = 1; k <= 4; k++) begin
         tick();
         n_cmp++; if (clk_en !== (k == 4)) begin n_fail++;
            $display("FAIL restart_pulse_k%0d: got %b want %b", k, clk_en, (k == 4)); end
      end
      n_cmp++; if (cycle_count !== 8'd1) begin n_fail++;
         $display("FAIL restart_count: got %0d want 1", cycle_count); end
   endtask

   initial begin
      rst    = 1'b1;
      step_n = 1'b1;
      mode_n = 1'b1;
      halt_i = 1'b0;
      test_reset();
      test_manual_step();
      test_run();
      test_halt();
      test_simultaneous();
      test_wrap();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
